// File: rtl/cc_ser_pkg.sv
// cc_ser_pkg: shared types, entry field positions and burst-length helper for the line serializer.
package cc_ser_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic MODE_INCR = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    // Entry layout MSB to LSB: {id, wrap, offset, line}
    function automatic int unsigned line_lsb();
        return 0;
    endfunction

    function automatic int unsigned ofs_lsb(input int unsigned line_w);
        return line_w;
    endfunction

    function automatic int unsigned wrap_pos(input int unsigned line_w, input int unsigned ofs_w);
        return line_w + ofs_w;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned line_w, input int unsigned ofs_w);
        return line_w + ofs_w + 1;
    endfunction

    function automatic int unsigned burst_len(input logic wrap, input int unsigned ofs, input int unsigned beats);
        return (wrap == MODE_WRAP) ? beats : beats - ofs;
    endfunction

endpackage

// File: rtl/cc_skid_buffer.sv
// cc_skid_buffer: two-entry valid/ready skid buffer; all downstream outputs are flop outputs.
module cc_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_busy
);
    logic         r_out_valid, r_skid_valid;
    logic [W-1:0] r_out_data, r_skid_data;

    assign o_ready = !r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_busy  = r_out_valid || r_skid_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else if (i_ready || !r_out_valid) begin
            r_out_valid  <= r_skid_valid || i_valid;
            r_out_data   <= r_skid_valid ? r_skid_data : i_data;
            r_skid_valid <= 1'b0;
        end else if (i_valid && !r_skid_valid) begin
            // Output stalled: park the beat already accepted upstream
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end
endmodule

// File: rtl/cc_line_serializer.sv
// cc_line_serializer: pops cache-line entries and emits WRAP/INCR R bursts of BEAT_W-bit beats.
// Define CC_SER_OUTREG_EN to register all R outputs through a skid buffer (+1 cycle latency).
module cc_line_serializer
    import cc_ser_pkg::*;
#(
    parameter  int LINE_W  = 512,
    parameter  int BEAT_W  = 64,
    parameter  int ID_W    = 4,
    localparam int BEATS   = LINE_W / BEAT_W,
    localparam int OFS_W   = $clog2(BEATS),
    localparam int ENTRY_W = ID_W + 1 + OFS_W + LINE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty_i,
    input  logic [ENTRY_W-1:0] fifo_rdata_i,
    output logic               fifo_rden_o,
    output logic [ID_W-1:0]    rid_o,
    output logic [BEAT_W-1:0]  rdata_o,
    output logic               rlast_o,
    output logic               rvalid_o,
    input  logic               rready_i,
    output logic               busy_o
);
    if (LINE_W % BEAT_W != 0) begin : g_chk_div
        $error("LINE_W must be a multiple of BEAT_W");
    end
    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_chk_pow2
        $error("LINE_W/BEAT_W must be a power of two >= 2");
    end

    state_t              r_state, w_state_nxt;
    logic [LINE_W-1:0]   r_line;
    logic [ID_W-1:0]     r_id;
    logic                r_wrap;
    logic [OFS_W-1:0]    r_ofs;
    logic [OFS_W:0]      r_cnt;
    logic [OFS_W:0]      w_len;
    logic [OFS_W-1:0]    w_idx;
    logic [BEAT_W-1:0]   w_words [BEATS];
    logic [BEAT_W-1:0]   w_sdata;
    logic [ID_W-1:0]     w_sid;
    logic                w_svalid, w_sready, w_slast, w_fire, w_pop;

    for (genvar i = 0; i < BEATS; i++) begin : g_word
        assign w_words[i] = r_line[LINE_W-1-i*BEAT_W -: BEAT_W];
    end

    assign w_len    = (OFS_W+1)'(burst_len(r_wrap, 32'(r_ofs), BEATS));
    assign w_idx    = r_ofs + r_cnt[OFS_W-1:0];
    assign w_svalid = (r_state == SEND);
    assign w_slast  = w_svalid && (r_cnt == w_len - (OFS_W+1)'(1));
    assign w_sdata  = w_svalid ? w_words[w_idx] : '0;
    assign w_sid    = w_svalid ? r_id : '0;
    assign w_fire   = w_svalid && w_sready;
    // Chained pop on the last handshake keeps back-to-back lines bubble-free
    assign w_pop       = rst_n && !fifo_empty_i && (r_state == IDLE || (w_fire && w_slast));
    assign fifo_rden_o = w_pop;

    always_comb begin
        w_state_nxt = r_state;
        if (w_pop)
            w_state_nxt = SEND;
        else if (w_fire && w_slast)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_line <= fifo_rdata_i[line_lsb() +: LINE_W];
                r_ofs  <= fifo_rdata_i[ofs_lsb(LINE_W) +: OFS_W];
                r_wrap <= fifo_rdata_i[wrap_pos(LINE_W, OFS_W)];
                r_id   <= fifo_rdata_i[id_lsb(LINE_W, OFS_W) +: ID_W];
                r_cnt  <= '0;
            end else if (w_fire) begin
                r_cnt <= r_cnt + (OFS_W+1)'(1);
            end
        end
    end

`ifdef CC_SER_OUTREG_EN
    localparam int PAY_W = ID_W + 1 + BEAT_W;
    logic [PAY_W-1:0] w_rpay;
    logic             w_skid_busy;

    cc_skid_buffer #(.W(PAY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_svalid),
        .o_ready (w_sready),
        .i_data  ({w_sid, w_slast, w_sdata}),
        .o_valid (rvalid_o),
        .i_ready (rready_i),
        .o_data  (w_rpay),
        .o_busy  (w_skid_busy)
    );

    assign {rid_o, rlast_o, rdata_o} = w_rpay;
    assign busy_o = w_svalid || w_skid_busy;
`else
    assign w_sready = rready_i;
    assign rvalid_o = w_svalid;
    assign rdata_o  = w_sdata;
    assign rid_o    = w_sid;
    assign rlast_o  = w_slast;
    assign busy_o   = w_svalid;
`endif
endmodule

// File: tb/tb_cc_line_serializer.sv
// tb_cc_line_serializer: scoreboard bench for cc_line_serializer (default 512/64/4 configuration).
module tb_cc_line_serializer;
`ifdef CC_SER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic WRAP = 1'b1;
    localparam logic INCR = 1'b0;

    logic         clk;
    logic         rst_n;
    logic         fifo_empty_i;
    logic [519:0] fifo_rdata_i;
    logic         fifo_rden_o;
    logic [3:0]   rid_o;
    logic [63:0]  rdata_o;
    logic         rlast_o;
    logic         rvalid_o;
    logic         rready_i;
    logic         busy_o;

    cc_line_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdata_i (fifo_rdata_i),
        .fifo_rden_o  (fifo_rden_o),
        .rid_o        (rid_o),
        .rdata_o      (rdata_o),
        .rlast_o      (rlast_o),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: driver writes, DUT pop strobe advances the read pointer
    logic [519:0] fifo_mem [0:31];
    logic [7:0]   fifo_wr = 8'd0;
    logic [7:0]   fifo_rd = 8'd0;
    assign fifo_empty_i = (fifo_rd == fifo_wr);
    assign fifo_rdata_i = fifo_mem[fifo_rd[4:0]];
    always @(posedge clk) if (fifo_rden_o) fifo_rd <= fifo_rd + 8'd1;

    // Scoreboard: expected {rid, rlast, rdata} per beat
    logic [68:0] exp_mem [0:255];
    int exp_wr = 0, exp_flush = 0, exp_rd = 0;
    int zero_req = 0, zero_ack = 0, lat_req = 0, lat_ack = 0;
    int exp_run = 0, tmo = 0;
    bit done = 1'b0;

    int n_cmp = 0, n_err = 0, n_pop = 0, n_beat = 0, cyc = 0, pop_cyc = 0, run = 0;
    bit lat_wait = 1'b0, prev_stall = 1'b0;
    logic [69:0] prev_pay;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_rd < exp_flush) exp_rd = exp_flush;
        if (zero_req != zero_ack) begin
            zero_ack = zero_req;
            chk("reset_outputs_zero", {fifo_rden_o, rvalid_o, rlast_o, busy_o, rid_o, rdata_o}, '0);
        end
        if (rst_n) begin
            if (fifo_rden_o) n_pop++;
            if (lat_req != lat_ack && fifo_rden_o) begin
                lat_ack  = lat_req;
                pop_cyc  = cyc;
                lat_wait = 1'b1;
            end else if (lat_wait && (rvalid_o || cyc - pop_cyc > 8)) begin
                chk("first_beat_latency", 128'(cyc - pop_cyc), 128'(LAT));
                lat_wait = 1'b0;
            end
            if (prev_stall)
                chk("stall_stable", {rvalid_o, rlast_o, rid_o, rdata_o}, prev_pay);
            if (rvalid_o && rready_i) begin
                chk("beat_expected", 128'(exp_wr > exp_rd), 128'(1));
                if (exp_wr > exp_rd) begin
                    chk("beat", {rid_o, rlast_o, rdata_o}, exp_mem[exp_rd[7:0]]);
                    exp_rd++;
                end
                n_beat++;
            end
            prev_stall = rvalid_o && !rready_i;
            prev_pay   = {rvalid_o, rlast_o, rid_o, rdata_o};
            if (rvalid_o) run++;
            else begin
                if (run > 0 && exp_run != 0) chk("valid_run_length", 128'(run), 128'(exp_run));
                run = 0;
            end
        end else begin
            prev_stall = 1'b0;
            run = 0;
        end
        cyc++;
        if (done) begin
            chk("pop_count", 128'(n_pop), 128'(fifo_wr));
            chk("scoreboard_drained", 128'(exp_wr - exp_rd), '0);
            chk("wait_timeouts", 128'(tmo), '0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    // Queue one entry; word k of entry n carries {n, 0..., k}. ord lists word indices MSB nibble first.
    task automatic push(input logic [3:0] id, input logic wrap, input logic [2:0] ofs, input int n, input logic [31:0] ord);
        logic [511:0] line;
        logic [3:0]   k;
        for (int w = 0; w < 8; w++) line[511-64*w -: 64] = {fifo_wr, 48'h0, 8'(w)};
        fifo_mem[fifo_wr[4:0]] = {id, wrap, ofs, line};
        for (int i = 0; i < n; i++) begin
            k = ord[31-4*i -: 4];
            exp_mem[exp_wr[7:0]] = {id, (i == n - 1), fifo_wr, 48'h0, 8'(k)};
            exp_wr++;
        end
        fifo_wr = fifo_wr + 8'd1;
    endtask

    task automatic wait_idle(input bit rnd);
        int i;
        for (i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rnd) rready_i = ($urandom_range(0, 99) >= 40);
            if (exp_rd >= exp_wr && !busy_o && fifo_empty_i) break;
        end
        if (i == 400) tmo++;
        rready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base, i;
        rst_n    = 1'b0;
        rready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 zero_req++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        lat_req++; push(4'd1, WRAP, 3'd5, 8, 32'h5670_1234); wait_idle(0);
        lat_req++; push(4'd2, INCR, 3'd5, 3, 32'h5670_0000); wait_idle(0);
        lat_req++; push(4'd4, INCR, 3'd0, 8, 32'h0123_4567); wait_idle(0);

        push(4'd1, WRAP, 3'd3, 8, 32'h3456_7012);
        push(4'd2, INCR, 3'd2, 6, 32'h2345_6700);
        push(4'd4, WRAP, 3'd7, 8, 32'h7012_3456);
        wait_idle(1);

        exp_run = 10;
        push(4'd3, WRAP, 3'd2, 8, 32'h2345_6701);
        push(4'd9, INCR, 3'd6, 2, 32'h6700_0000);
        wait_idle(0);
        exp_run = 0;

        push(4'd5, WRAP, 3'd1, 8, 32'h1234_5670);
        base = n_beat;
        for (i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (n_beat - base == 3) break;
        end
        if (i == 50) tmo++;
        rst_n    = 1'b0;
        rready_i = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rready_i  = 1'b1;
        exp_flush = exp_wr;
        zero_req++;
        @(posedge clk); #1;
        lat_req++; push(4'd7, INCR, 3'd4, 4, 32'h4567_0000); wait_idle(0);

        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/cc_line_serializer.md
# cc_line_serializer

Parametrised cache-line serializer for the cache controller read-return path. Pops one line entry from the miss/hit data FIFO, holds it locally, and emits it as an AXI-style R burst of BEAT_W-bit beats. Supports critical-word-first WRAP ordering and truncated INCR ordering, carries a transaction ID, and chains consecutive lines with no idle cycle.

## Interface
- LINE_W, 512: cache line width in bits.
- BEAT_W, 64: R data beat width; LINE_W multiple of BEAT_W.
- ID_W, 4: transaction ID width.
- BEATS (derived), LINE_W/BEAT_W: power of two, ≥2; OFS_W = $clog2(BEATS).
- ENTRY_W (derived), ID_W+1+OFS_W+LINE_W: FIFO entry width.

- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- fifo_empty_i  in  1  data FIFO empty.
- fifo_rdata_i  in  ENTRY_W  FIFO head entry, fields {id, wrap, offset, line} MSB to LSB; word 0 = line[LINE_W-1 -: BEAT_W].
- fifo_rden_o  out  1  pop strobe; head is consumed in the same cycle.
- rid_o  out  ID_W  burst ID.
- rdata_o  out  BEAT_W  beat data.
- rlast_o  out  1  final beat of burst.
- rvalid_o  out  1  beat valid.
- rready_i  in  1  downstream accept.
- busy_o  out  1  a line is held or a beat is in flight.

## Operation
- State machine with two states, IDLE and SEND. Per-line registers: line_q, id_q, wrap_q, ofs_q, cnt_q[OFS_W:0].
- IDLE with !fifo_empty_i: assert fifo_rden_o, capture head fields, clear cnt_q, go to SEND.
- SEND: rvalid_o=1. Beat index idx = ofs_q + cnt_q[OFS_W-1:0], truncated to OFS_W bits, so it wraps modulo BEATS. rdata_o = word idx. rid_o = id_q.
- WRAP (wrap=1): BEATS beats. Order: ofs, ofs+1, …, wrapping through 0.
- INCR (wrap=0): BEATS-ofs_q beats, from word ofs to word BEATS-1. Offset 0 gives a full line.
- rlast_o = 1 on the final beat: cnt_q == len-1, where len is BEATS or BEATS-ofs_q.
- On each rvalid_o && rready_i, cnt_q increments. On the rlast handshake:
  - if !fifo_empty_i: pop and load the next entry in the same cycle, stay in SEND;
  - else go to IDLE.
- rvalid_o, rdata_o, rid_o and rlast_o are held stable until handshake. No pop ever happens mid-burst.
- busy_o = (state == SEND), OR the output stage holds data.

## Timing
- Reset: state IDLE, cnt_q 0. Every output is 0: fifo_rden_o, rvalid_o, rlast_o, rdata_o, rid_o, busy_o.
- Reset mid-burst: the burst is abandoned and the popped entry is discarded. rvalid_o is 0 in the cycle after the reset edge.
- Pop in cycle T means first beat valid in T+1. With rready_i held high, one beat per cycle.
- Back-to-back lines: the last beat of line N and the pop of line N+1 share cycle T. First beat of N+1 is in T+1, so there is no bubble.
- FIFO empty at the last handshake: IDLE for at least one cycle, and the next pop happens no earlier than the following cycle.
- Without the macro below, fifo_rden_o depends combinationally on rready_i (last-beat chaining path).

## Configuration
- CC_SER_OUTREG_EN defined:
  - R outputs come from a 2-entry skid buffer, so rvalid_o/rdata_o/rid_o/rlast_o are all flop outputs.
  - No combinational path from rready_i to any output.
  - Adds +1 cycle latency: pop at T gives first beat at T+2.
  - Throughput stays one beat per cycle. Back-to-back lines still have no bubble.
- Undefined: outputs are driven directly from the line registers, as described above.

## Structure
- Package cc_ser_pkg holds:
  - entry field-slicing functions (id/wrap/offset/line);
  - the WRAP/INCR mode localparams;
  - the burst-length function len(wrap, ofs).
- Sub-module cc_skid_buffer: parametrised payload width, valid/ready on both sides. Instantiated only under CC_SER_OUTREG_EN.
- Elaboration assertions: LINE_W % BEAT_W == 0 and BEATS a power of two ≥2.

## Test plan
- WRAP, ofs=5, BEATS=8, rready_i=1 → 8 beats in words 5,6,7,0,1,2,3,4. rlast_o on the 8th beat only. Exactly one fifo_rden_o pulse.
- INCR, ofs=5 → 3 beats in words 5,6,7, rlast_o on word 7. INCR with ofs=0 → 8 beats in words 0..7.
- Random rready_i toggling, ~40% stall → no beat lost or duplicated. Payload stable while rvalid_o=1 and rready_i=0.
- Two entries queued (id 3 WRAP ofs 2, id 9 INCR ofs 6) → 10 consecutive valid cycles with rready_i=1, no bubble. rid_o switches 3→9 right after the rlast beat.
- Assert rst_n=0 on the 4th beat of a WRAP burst → next cycle all outputs 0, state IDLE. The next FIFO entry then bursts correctly from its own offset.
- Run all of the above with CC_SER_OUTREG_EN defined and undefined → identical beat streams. First-beat latency is 1 vs 2 cycles after the pop.
